// File: rtl/farm_sensor_conditioner_if.sv
// Bus between the farm-road loop detector conditioner and the traffic
// light controller: raw detector level and lamp feedback in, conditioned
// request and status out.
interface farm_sensor_conditioner_if #(
    parameter int CNT_W = 4
);
    logic             raw_detect;
    logic [2:0]       light_FM;
    logic             sensor;
    logic             arrival;
    logic [CNT_W-1:0] pending_count;
    logic             fault;

    // Controller / environment side.
    modport master (
        output raw_detect,
        output light_FM,
        input  sensor,
        input  arrival,
        input  pending_count,
        input  fault
    );

    // Conditioner side.
    modport slave (
        input  raw_detect,
        input  light_FM,
        output sensor,
        output arrival,
        output pending_count,
        output fault
    );
endinterface

// File: rtl/farm_sensor_conditioner.sv
// farm_sensor_conditioner
// Synchronises and debounces the farm-road vehicle loop, counts accepted
// vehicles and raises a registered service request until the controller
// shows farm-road green.
// Optional feature macro: FARM_STUCK_DETECT_EN (stuck-detector fault with a
// fail-safe service request). Without it, fault is tied low.
module farm_sensor_conditioner #(
    parameter int DEB_CYCLES   = 4,
    parameter int CNT_W        = 4,
    parameter int STUCK_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    farm_sensor_conditioner_if.slave  bus
);

    localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQUEST = 2'b01,
        SERVING = 2'b10
    } state_t;

    if (DEB_CYCLES < 2 || STUCK_CYCLES < 2) begin : g_bad_cfg
        $error("farm_sensor_conditioner: DEB_CYCLES and STUCK_CYCLES must be >= 2");
    end

    logic             sync1_r;
    logic             sync_q_r;
    logic [DW-1:0]    deb_cnt_r;
    logic [DW-1:0]    deb_cnt_next_s;
    logic             deb_r;
    logic             deb_next_s;
    logic             deb_rise_s;
    logic             green_s;
    logic             req_s;
    logic [CNT_W-1:0] pend_r;
    logic [CNT_W-1:0] pend_next_s;
    logic             arrival_r;
    logic             sensor_r;
    logic             fault_r;
    state_t           state_r;
    state_t           state_next_s;

    // Anything other than the exact one-hot green code counts as not green.
    assign green_s = (bus.light_FM == 3'b001);

    // Two-flop synchroniser on the asynchronous loop detector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r  <= 1'b0;
            sync_q_r <= 1'b0;
        end else begin
            sync1_r  <= bus.raw_detect;
            sync_q_r <= sync1_r;
        end
    end

    // Debounce: the counter tracks the level entering the second stage, so
    // when it expires sync_q already holds a level that has differed from
    // deb for DEB_CYCLES consecutive edges; deb then takes sync_q.
    always_comb begin
        deb_cnt_next_s = deb_cnt_r;
        deb_next_s     = deb_r;
        if (sync1_r != deb_r) begin
            if (deb_cnt_r == DEB_LAST) begin
                deb_next_s     = sync_q_r;
                deb_cnt_next_s = '0;
            end else begin
                deb_cnt_next_s = deb_cnt_r + DW'(1);
            end
        end else begin
            deb_cnt_next_s = '0;
        end
    end

    assign deb_rise_s = !deb_r && deb_next_s;

    // Debounced level and its stability counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_r     <= 1'b0;
            deb_cnt_r <= '0;
        end else begin
            deb_r     <= deb_next_s;
            deb_cnt_r <= deb_cnt_next_s;
        end
    end

`ifdef FARM_STUCK_DETECT_EN
    localparam int SW = $clog2(STUCK_CYCLES + 1);
    localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);
    localparam logic [SW-1:0] STUCK_MAX  = SW'(STUCK_CYCLES);

    logic [SW-1:0] stuck_cnt_r;

    // Stuck-detector timer: a debounced-high level lasting STUCK_CYCLES
    // latches fault until the debounced level drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stuck_cnt_r <= '0;
            fault_r     <= 1'b0;
        end else if (!deb_next_s) begin
            stuck_cnt_r <= '0;
            fault_r     <= 1'b0;
        end else begin
            if (stuck_cnt_r != STUCK_MAX) begin
                stuck_cnt_r <= stuck_cnt_r + SW'(1);
            end else begin
                stuck_cnt_r <= stuck_cnt_r;
            end
            fault_r <= fault_r || (stuck_cnt_r == STUCK_LAST);
        end
    end

    assign req_s = (pend_r != '0) || fault_r;
`else
    assign fault_r = 1'b0;
    assign req_s   = (pend_r != '0);
`endif

    // Next state: request only against a non-green farm road, retire on green.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s && !green_s) begin
                    state_next_s = REQUEST;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQUEST: begin
                if (green_s) begin
                    state_next_s = SERVING;
                end else begin
                    state_next_s = REQUEST;
                end
            end
            SERVING: begin
                if (!green_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SERVING;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Pending count: clearing on service wins over a simultaneous arrival;
    // vehicles arriving while the farm road stays green pass uncounted.
    always_comb begin
        pend_next_s = pend_r;
        if (state_r == REQUEST && green_s) begin
            pend_next_s = '0;
        end else if (deb_rise_s && !(state_r == SERVING && green_s) &&
                     (pend_r != CNT_MAX)) begin
            pend_next_s = pend_r + CNT_W'(1);
        end else begin
            pend_next_s = pend_r;
        end
    end

    // Registered FSM state and outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            sensor_r  <= 1'b0;
            arrival_r <= 1'b0;
            pend_r    <= '0;
        end else begin
            state_r   <= state_next_s;
            sensor_r  <= (state_next_s == REQUEST);
            arrival_r <= deb_rise_s;
            pend_r    <= pend_next_s;
        end
    end

    assign bus.sensor        = sensor_r;
    assign bus.arrival       = arrival_r;
    assign bus.pending_count = pend_r;
    assign bus.fault         = fault_r;

endmodule
